// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the ALU floating-point units.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int FRC_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [FRC_W-1:0] frc;
  } fp32_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_e;

  // Subnormals count as zero: the units never operate on them.
  function automatic logic is_zero(input fp32_t a);
    return a.exp == '0;
  endfunction

  function automatic logic is_inf(input fp32_t a);
    return (a.exp == '1) && (a.frc == '0);
  endfunction

  function automatic logic is_nan(input fp32_t a);
    return (a.exp == '1) && (a.frc != '0);
  endfunction

  function automatic rmode_e decode_rmode(input logic [2:0] m);
    if (m > 3'd4) return RM_RNE;
    return rmode_e'(m);
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational binary32 rounder with overflow saturation and flush-to-zero.
module fp_round
  import fp_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [23:0]       i_mant,
  input  logic              i_g,
  input  logic              i_r,
  input  logic              i_s,
  input  logic [2:0]        i_rmode,
  output logic [31:0]       o_z,
  output logic              o_ovrf,
  output logic              o_udrf
);

  rmode_e            w_mode;
  logic              w_any;
  logic              w_inc;
  logic [24:0]       w_sum;
  logic [22:0]       w_frc;
  logic signed [9:0] w_exp;
  logic              w_to_inf;

  assign w_mode = decode_rmode(i_rmode);
  assign w_any  = i_g | i_r | i_s;

  always_comb begin
    w_inc = 1'b0;
    case (w_mode)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & w_any;
      RM_RUP:  w_inc = ~i_sign & w_any;
      RM_RMM:  w_inc = i_g;
      default: w_inc = i_g & (i_r | i_s | i_mant[0]);
    endcase
  end

  // A carry out of the mantissa leaves 1.000..0, so only the exponent moves.
  assign w_sum = {1'b0, i_mant} + {24'd0, w_inc};
  assign w_frc = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
  assign w_exp = i_exp + {9'd0, w_sum[24]};

  assign w_to_inf = (w_mode == RM_RNE) || (w_mode == RM_RMM) ||
                    ((w_mode == RM_RUP) && !i_sign) ||
                    ((w_mode == RM_RDN) && i_sign);

  always_comb begin
    o_ovrf = 1'b0;
    o_udrf = 1'b0;
    o_z    = {i_sign, w_exp[7:0], w_frc};
    if (w_exp >= 10'sd255) begin
      o_ovrf = 1'b1;
      o_z    = w_to_inf ? {i_sign, PINF[30:0]} : {i_sign, MAXF[30:0]};
    end else if (w_exp <= 10'sd0) begin
      o_udrf = 1'b1;
      o_z    = {i_sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider: radix-2 restoring mantissa division, one quotient bit per cycle.
module fp_div_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        div_zero
);

  state_e            r_state;
  state_e            w_next;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [24:0]       r_rem;
  logic [23:0]       r_divisor;
  logic [25:0]       r_quo;
  logic [4:0]        r_cnt;
  logic [2:0]        r_rmode;
  logic [31:0]       r_z;
  logic              r_ovrf;
  logic              r_udrf;
  logic              r_dz;

  fp32_t             w_x;
  fp32_t             w_y;
  logic              w_sign;
  logic              w_zx, w_zy, w_ix, w_iy, w_nx, w_ny;
  logic              w_special;
  logic [31:0]       w_spec_z;
  logic              w_spec_dz;
  logic [23:0]       w_mx;
  logic [23:0]       w_my;
  logic              w_adj;
  logic [24:0]       w_rem_init;
  logic signed [9:0] w_exp_init;
  logic              w_rem_ge;
  logic [24:0]       w_diff;
  logic [24:0]       w_rem_next;
  logic [31:0]       w_round_z;
  logic              w_round_ovrf;
  logic              w_round_udrf;

  assign w_x    = fp_X;
  assign w_y    = fp_Y;
  assign w_sign = w_x.sign ^ w_y.sign;
  assign w_zx   = is_zero(w_x);
  assign w_zy   = is_zero(w_y);
  assign w_ix   = is_inf(w_x);
  assign w_iy   = is_inf(w_y);
  assign w_nx   = is_nan(w_x);
  assign w_ny   = is_nan(w_y);

  assign w_special = w_zx | w_zy | w_ix | w_iy | w_nx | w_ny;

  always_comb begin
    w_spec_z  = QNAN;
    w_spec_dz = 1'b0;
    if (w_nx || w_ny || (w_zx && w_zy) || (w_ix && w_iy)) begin
      w_spec_z = QNAN;
    end else if (w_ix) begin
      w_spec_z = {w_sign, PINF[30:0]};
    end else if (w_iy) begin
      w_spec_z = {w_sign, 31'd0};
    end else if (w_zy) begin
      w_spec_z  = {w_sign, PINF[30:0]};
      w_spec_dz = 1'b1;
    end else begin
      w_spec_z = {w_sign, 31'd0};
    end
  end

  // Pre-align so the first quotient bit is always the integer 1.
  assign w_mx       = {1'b1, w_x.frc};
  assign w_my       = {1'b1, w_y.frc};
  assign w_adj      = w_mx < w_my;
  assign w_rem_init = w_adj ? {w_mx, 1'b0} : {1'b0, w_mx};
  assign w_exp_init = {2'b00, w_x.exp} - {2'b00, w_y.exp} + 10'd127 - {9'd0, w_adj};

  assign w_rem_ge   = r_rem >= {1'b0, r_divisor};
  assign w_diff     = w_rem_ge ? (r_rem - {1'b0, r_divisor}) : r_rem;
  assign w_rem_next = w_diff << 1;

  fp_round u_round (
    .i_sign  (r_sign),
    .i_exp   (r_exp),
    .i_mant  (r_quo[25:2]),
    .i_g     (r_quo[1]),
    .i_r     (r_quo[0]),
    .i_s     (r_rem != '0),
    .i_rmode (r_rmode),
    .o_z     (w_round_z),
    .o_ovrf  (w_round_ovrf),
    .o_udrf  (w_round_udrf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (start) w_next = w_special ? S_DONE : S_DIV;
      end
      S_DIV: begin
        if (r_cnt == 5'd25) w_next = S_ROUND;
      end
      S_ROUND: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_rmode   <= '0;
      r_z       <= '0;
      r_ovrf    <= 1'b0;
      r_udrf    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign  <= w_sign;
            r_rmode <= r_mode;
            if (w_special) begin
              r_z    <= w_spec_z;
              r_dz   <= w_spec_dz;
              r_ovrf <= 1'b0;
              r_udrf <= 1'b0;
            end else begin
              r_rem     <= w_rem_init;
              r_divisor <= w_my;
              r_exp     <= w_exp_init;
              r_quo     <= '0;
              r_cnt     <= '0;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[24:0], w_rem_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_ROUND: begin
          r_z    <= w_round_z;
          r_ovrf <= w_round_ovrf;
          r_udrf <= w_round_udrf;
          r_dz   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign fp_Z     = r_z;
  assign ovrf     = r_ovrf;
  assign udrf     = r_udrf;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter with hand-computed quotients.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        div_zero;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .div_zero  (div_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One full transaction: accept, measure latency, check result, then drain.
  task automatic applyStimulus(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [2:0] mode, input logic [31:0] expZ,
                               input logic [2:0] expFlags, input int expLat);
    int waitCnt;
    int lat;
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, "_ready_in"}, {31'd0, in_ready}, 32'd1);
    fp_X = x; fp_Y = y; r_mode = mode; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; fp_X = 32'hDEADBEEF; fp_Y = 32'h12345678; r_mode = 3'b001;
    checkOutput({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_z"}, fp_Z, expZ);
    checkOutput({tag, "_flags"}, {29'd0, ovrf, udrf, div_zero}, {29'd0, expFlags});
    checkOutput({tag, "_ready_done"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    fp_X = '0; fp_Y = '0; r_mode = '0;
    #12;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_z", fp_Z, 32'd0);
    checkOutput("rst_flags", {29'd0, ovrf, udrf, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // flags order: {ovrf, udrf, div_zero}
    applyStimulus("six_by_two",  32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 3'b000, 28);
    applyStimulus("neg_six",     32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, 3'b000, 28);
    applyStimulus("third_rne",   32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 3'b000, 28);
    applyStimulus("third_rtz",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 3'b000, 28);
    applyStimulus("third_rup",   32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 3'b000, 28);
    applyStimulus("third_rdn",   32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 3'b000, 28);
    applyStimulus("third_rmm",   32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 3'b000, 28);
    applyStimulus("third_m5",    32'h3F800000, 32'h40400000, 3'b101, 32'h3EAAAAAB, 3'b000, 28);
    applyStimulus("nthird_rdn",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 3'b000, 28);
    applyStimulus("nthird_rup",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 3'b000, 28);
    applyStimulus("div_zero",    32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 3'b001, 1);
    applyStimulus("div_subn",    32'hBF800000, 32'h00400000, 3'b000, 32'hFF800000, 3'b001, 1);
    applyStimulus("zero_zero",   32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 3'b000, 1);
    applyStimulus("inf_inf",     32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 3'b000, 1);
    applyStimulus("nan_in",      32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 3'b000, 1);
    applyStimulus("inf_fin",     32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 3'b000, 1);
    applyStimulus("fin_inf",     32'hC0000000, 32'h7F800000, 3'b000, 32'h80000000, 3'b000, 1);
    applyStimulus("zero_fin",    32'h00000000, 32'hC0000000, 3'b000, 32'h80000000, 3'b000, 1);
    applyStimulus("ovf_rne",     32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 3'b100, 28);
    applyStimulus("ovf_rtz",     32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 3'b100, 28);
    applyStimulus("novf_rdn",    32'hFF000000, 32'h3E800000, 3'b010, 32'hFF800000, 3'b100, 28);
    applyStimulus("novf_rup",    32'hFF000000, 32'h3E800000, 3'b011, 32'hFF7FFFFF, 3'b100, 28);
    applyStimulus("udf",         32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 3'b010, 28);

    // Backpressure: result must hold and start must be ignored.
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    fp_X = 32'h3F800000; fp_Y = 32'h40400000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_lat", lat, 28);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_z", fp_Z, 32'h40400000);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_ready_after", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_valid_after", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of the mantissa loop.
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_z", fp_Z, 32'd0);
    checkOutput("mid_rst_flags", {29'd0, ovrf, udrf, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("post_rst", 32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 3'b000, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
Iterative binary32 floating-point divider, fp_Z = fp_X / fp_Y. It is the inverse-direction companion of the ALU multiplier and sits beside it in the ALU.
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on both input and output.
- Subnormal policy matches the multiplier: subnormal inputs are treated as zero and underflowed results are flushed to zero.

Parameters:
- None; the format is fixed to binary32 (EXP_W=8, FRC_W=23 and BIAS=127 are package constants).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request valid; operands presented
in_ready  out  1  block can accept; high only in IDLE
fp_X  in  32  dividend
fp_Y  in  32  divisor
r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
fp_Z  out  32  quotient
ovrf  out  1  overflow flag, valid with out_valid
udrf  out  1  underflow (flush) flag, valid with out_valid
div_zero  out  1  finite nonzero divided by zero, valid with out_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: FSM=IDLE; out_valid, fp_Z, ovrf, udrf, div_zero all 0; in_ready=1.
- Reset mid-operation aborts immediately; no result is produced.
- Accept: on a clock edge where start && in_ready, capture fp_X, fp_Y and r_mode. Inputs may change afterwards.
- FSM states: IDLE, DIV, ROUND, DONE.
  - IDLE -> DONE on accept when the operands are a special case.
  - IDLE -> DIV on accept otherwise.
  - DIV -> ROUND after 26 iterations.
  - ROUND -> DONE.
  - DONE -> IDLE when out_valid && out_ready.
- Latency:
  - Special case: out_valid is high the cycle after the accept edge.
  - Normal case: out_valid rises 28 cycles after the accept edge.
  - After the output transfer, in_ready rises the next cycle (one bubble; no back-to-back acceptance).
- Backpressure: while out_valid && !out_ready, fp_Z and all flags hold stable and start is ignored.
- Classification:
  - zero = exp==0, including subnormals.
  - inf = exp==FF and frc==0.
  - nan = exp==FF and frc!=0.
  - sign = sX ^ sY for all results except NaN.
- Special cases, in priority order:
  1. Any NaN input, 0/0, or inf/inf -> 7FC00000, all flags 0.
  2. inf/finite -> signed inf.
  3. finite/inf -> signed zero.
  4. nonzero/zero -> signed inf, div_zero=1.
  5. zero/nonzero -> signed zero.
- Normal datapath:
  - Mantissas mX={1,frcX}, mY={1,frcY}.
  - If mX<mY: shift mX left by 1 and set adj=1.
  - Exponent E = eX - eY + 127 - adj, held as a 10-bit signed value.
  - Quotient is 26 bits: 1 integer bit, 23 fraction bits, G, R. Sticky S = (final remainder != 0).
- Rounding (ROUND state), with increment inc:
  - RNE: inc = G && (R || S || lsb).
  - RTZ: inc = 0.
  - RDN: inc = sign && (G||R||S).
  - RUP: inc = !sign && (G||R||S).
  - RMM: inc = G.
  - A mantissa carry-out sets E = E+1.
- Overflow: E >= 255 -> ovrf=1.
  - Result is signed inf for RNE and RMM, for RUP with a positive sign, and for RDN with a negative sign.
  - Otherwise the result is signed 7F7FFFFF (max finite).
- Underflow: E <= 0 after rounding -> result is signed zero, udrf=1. No subnormal output is ever produced.

Decomposition:
- Shared package fp_pkg:
  - fp32_t struct {sign, exp[7:0], frc[22:0]}.
  - rmode_e enum.
  - Constants BIAS, QNAN=7FC00000, PINF=7F800000, MAXF=7F7FFFFF.
  - Classification functions is_zero, is_inf, is_nan.
- Sub-module fp_round, reusable by the multiplier:
  - Inputs: sign, 10-bit E, 24-bit mantissa, G/R/S, r_mode.
  - Outputs: fp_Z, ovrf, udrf.
  - Purely combinational; instantiated in ROUND.

Test Plan:
- 40C00000 / 40000000, RNE -> 40400000 exactly 28 cycles after accept; flags 0; in_ready low until the transfer plus 1 cycle.
- 3F800000 / 40400000: RNE -> 3EAAAAAB; RTZ -> 3EAAAAAA; RUP -> 3EAAAAAB; RDN -> 3EAAAAAA.
- Special cases, each with out_valid 1 cycle after accept:
  - 3F800000 / 00000000 -> 7F800000, div_zero=1.
  - BF800000 / 00400000 (subnormal) -> FF800000, div_zero=1.
  - 00000000 / 00000000 -> 7FC00000.
  - 7F800000 / 7F800000 -> 7FC00000.
- Overflow, 7F000000 / 3E800000: RNE -> 7F800000, ovrf=1; RTZ -> 7F7FFFFF, ovrf=1.
- Underflow, 00800000 / 40000000 -> 00000000, udrf=1.
- Backpressure: out_ready=0 for 5 cycles with start=1 -> fp_Z stable, no new accept.
- Reset mid-DIV: rst_n low at cycle 10 -> out_valid=0, in_ready=1, flags 0 immediately.
